// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: reset vector, memory geometry,
// NOP encoding and redirect state encodings.
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 4096;
  localparam int          DEF_IDX_W    = 12;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  // Redirect targets are always word aligned before use.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id.sv
// IF/ID pipeline register: squash beats stall, otherwise loads the current fetch.
module if_id_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        squash,
  input  logic        stall,
  input  logic [31:0] f_instr,
  input  logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc4,
  output logic        d_valid
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_instr <= NOP_INSTR;
      d_pc    <= 32'h0;
      d_pc4   <= 32'h0;
      d_valid <= 1'b0;
    end else if (squash) begin
      // Squash kills the instruction but keeps its PC for debug visibility.
      d_instr <= NOP_INSTR;
      d_valid <= 1'b0;
    end else if (!stall) begin
      d_instr <= f_instr;
      d_pc    <= f_pc;
      d_pc4   <= f_pc + 32'd4;
      d_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, a one-deep redirect capture for stalled cycles,
// the fault pulse and the fetched-instruction counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IM_WORDS = DEF_IM_WORDS,
  parameter int          IDX_W    = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             squash,
  input  logic             redir_valid,
  input  logic [31:0]      redir_target,
  output logic [IDX_W-1:0] imem_idx,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      d_instr,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_pc4,
  output logic             d_valid,
  output logic             redir_pending,
  output logic             fetch_fault,
  output logic [31:0]      fetch_count
);

  localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

  fetch_state_e state;
  logic [31:0]  pend_target;
  logic [31:0]  pc_off;
  logic         in_range;
  logic         load;
  logic [31:0]  target;
  logic [31:0]  pc_nxt;
  logic [31:0]  f_instr;

  // Offset below RESET_PC wraps to a huge value, so one compare covers both bounds.
  assign pc_off   = pc - RESET_PC;
  assign in_range = (pc_off < IM_BYTES) && (pc[1:0] == 2'b00);
  assign imem_idx = pc_off[IDX_W+1:2];
  assign load     = !squash && !stall;
  assign target   = word_align(redir_target);
  assign f_instr  = in_range ? imem_rdata : NOP_INSTR;

  always_comb begin
    pc_nxt = pc + 32'd4;
    if (redir_valid)
      pc_nxt = target;
    else if (state == HOLD)
      pc_nxt = pend_target;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      state         <= RUN;
      pend_target   <= 32'h0;
      redir_pending <= 1'b0;
      fetch_fault   <= 1'b0;
      fetch_count   <= 32'h0;
    end else begin
      fetch_fault <= load && !in_range;
      if (load)
        fetch_count <= fetch_count + 32'd1;
      if (stall) begin
        if (redir_valid) begin
          pend_target   <= target;
          state         <= HOLD;
          redir_pending <= 1'b1;
        end
      end else begin
        pc            <= pc_nxt;
        state         <= RUN;
        redir_pending <= 1'b0;
      end
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .squash  (squash),
    .stall   (stall),
    .f_instr (f_instr),
    .f_pc    (pc),
    .d_instr (d_instr),
    .d_pc    (d_pc),
    .d_pc4   (d_pc4),
    .d_valid (d_valid)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized checking of pc_fetch_unit against a cycle-level
// behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          WORDS  = 4096;
  localparam int          IW     = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall = 1'b0;
  logic          squash = 1'b0;
  logic          redir_valid = 1'b0;
  logic [31:0]   redir_target = 32'h0;
  logic [IW-1:0] imem_idx;
  logic [31:0]   imem_rdata;
  logic [31:0]   pc, d_instr, d_pc, d_pc4, fetch_count;
  logic          d_valid, redir_pending, fetch_fault;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_pc, m_dinstr, m_dpc, m_dpc4, m_cnt, m_pend;
  logic        m_dvalid, m_has_pend, m_fault;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] idx);
    return idx * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  assign imem_rdata = instr_of(32'(imem_idx));

  pc_fetch_unit #(.RESET_PC(RST_PC), .IM_WORDS(WORDS), .IDX_W(IW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .squash        (squash),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .imem_idx      (imem_idx),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .d_instr       (d_instr),
    .d_pc          (d_pc),
    .d_pc4         (d_pc4),
    .d_valid       (d_valid),
    .redir_pending (redir_pending),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_mem(input logic [31:0] a);
    return (a >= RST_PC) && (a < RST_PC + 4 * WORDS) && (a % 4 == 0);
  endfunction

  task automatic model_edge(input logic rn, st, sq, rv, input logic [31:0] rt);
    logic [31:0] tgt;
    tgt = (rt / 4) * 4;
    if (!rn) begin
      m_pc = RST_PC; m_dinstr = 0; m_dpc = 0; m_dpc4 = 0; m_dvalid = 0;
      m_cnt = 0; m_pend = 0; m_has_pend = 0; m_fault = 0;
      return;
    end
    m_fault = !sq && !st && !in_mem(m_pc);
    if (sq) begin
      m_dvalid = 0; m_dinstr = 0;
    end else if (!st) begin
      m_dpc = m_pc; m_dpc4 = m_pc + 4; m_dvalid = 1;
      m_dinstr = in_mem(m_pc) ? instr_of((m_pc - RST_PC) / 4) : 32'h0;
      m_cnt = m_cnt + 1;
    end
    if (st) begin
      if (rv) begin m_pend = tgt; m_has_pend = 1; end
    end else begin
      if (rv) m_pc = tgt;
      else if (m_has_pend) m_pc = m_pend;
      else m_pc = m_pc + 4;
      m_has_pend = 0;
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("d_pc", d_pc, m_dpc);
    chk("d_pc4", d_pc4, m_dpc4);
    chk("d_instr", d_instr, m_dinstr);
    chk("d_valid", 32'(d_valid), 32'(m_dvalid));
    chk("redir_pending", 32'(redir_pending), 32'(m_has_pend));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    chk("fetch_count", fetch_count, m_cnt);
    chk("imem_idx", 32'(imem_idx), 32'(((m_pc - RST_PC) / 4) % WORDS));
  endtask

  task automatic step(input logic rn, st, sq, rv, input logic [31:0] rt);
    reset_n = rn; stall = st; squash = sq; redir_valid = rv; redir_target = rt;
    @(posedge clk);
    model_edge(rn, st, sq, rv, rt);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset then free run
    step(0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_cnt", fetch_count, 32'h0);
    step(1, 0, 0, 0, 0);
    chk("run_pc1", pc, 32'h3004);
    step(1, 0, 0, 0, 0);
    chk("run_pc2", pc, 32'h3008);
    chk("run_dpc2", d_pc, 32'h3004);
    // Redirect with delay slot
    step(1, 0, 0, 1, 32'h3040);
    chk("redir_pc", pc, 32'h3040);
    chk("delay_dpc", d_pc, 32'h3008);
    chk("delay_valid", 32'(d_valid), 32'h1);
    step(1, 0, 0, 0, 0);
    chk("redir_dpc", d_pc, 32'h3040);
    chk("cnt4", fetch_count, 32'd4);
    // Stall with captured redirect
    step(1, 0, 0, 1, 32'h3010);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 32'h3100);
    chk("stall_pc", pc, 32'h3010);
    chk("pending", 32'(redir_pending), 32'h1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pend_applied", pc, 32'h3100);
    chk("pend_clr", 32'(redir_pending), 32'h0);
    // Squash with stall
    step(1, 0, 0, 1, 32'h3004);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("sq_dpc", d_pc, 32'h3004);
    chk("sq_valid", 32'(d_valid), 32'h0);
    // Alignment and out-of-range fetch
    step(1, 0, 0, 1, 32'h3003);
    chk("align_pc", pc, 32'h3000);
    step(1, 0, 0, 1, 32'h7000);
    step(1, 0, 0, 1, 32'h3000);
    chk("oor_instr", d_instr, 32'h0);
    chk("fault_on", 32'(fetch_fault), 32'h1);
    step(1, 0, 0, 0, 0);
    chk("fault_off", 32'(fetch_fault), 32'h0);
    // Reset during HOLD discards the pending target
    step(1, 1, 0, 1, 32'h3200);
    step(0, 1, 0, 0, 0);
    chk("rst_hold_pend", 32'(redir_pending), 32'h0);
    step(1, 0, 0, 0, 0);
    chk("rst_hold_pc", pc, 32'h3004);
    // Wrap of pc + 4 past 2^32
    step(1, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic rn, st, sq, rv;
      logic [31:0] rt;
      rn = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 3) == 0);
      sq = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0:       rt = $urandom;
        1:       rt = 32'hFFFF_FFFC;
        2:       rt = RST_PC + 4 * WORDS - 4 + $urandom_range(0, 11);
        default: rt = RST_PC + $urandom_range(0, 4 * WORDS - 1);
      endcase
      step(rn, st, sq, rv, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
